// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM control field layout, access size
// codes and the byte-lane enable helper used by the memory stage.
package mips_pkg;

  localparam int NB_MEM_DEF = 5;
  localparam int NB_WB_DEF  = 8;

  localparam int MEM_READ     = 0;
  localparam int MEM_WRITE    = 1;
  localparam int MEM_UNSIGNED = 2;
  localparam int MEM_SIZE_LO  = 3;
  localparam int MEM_SIZE_HI  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  // Misaligned halves/words are silently forced onto their natural boundary.
  function automatic logic [3:0] byte_enable(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: byte_enable = 4'b0001 << offset;
      SZ_HALF: byte_enable = offset[1] ? 4'b1100 : 4'b0011;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-enabled data memory: synchronous write, asynchronous access and debug
// read ports. Contents are never cleared.
module data_memory #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_we,
  input  logic [3:0]         i_be,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_REG-1:0]  i_wdata,
  output logic [NB_REG-1:0]  o_rdata,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_REG-1:0]  o_dbg_data
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB_REG-1:0] mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (i_be[lane]) mem[i_addr][8*lane +: 8] <= i_wdata[8*lane +: 8];
      end
    end
  end

  assign o_rdata    = mem[i_addr];
  assign o_dbg_data = mem[i_dbg_addr];

endmodule

// File: rtl/memory_access.sv
// MIPS memory stage: byte/half/word loads and stores into the data memory,
// with the load result and pass-through fields registered for write-back.
module memory_access
  import mips_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_MEM  = NB_MEM_DEF,
  parameter int NB_WB   = NB_WB_DEF,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_REG-1:0]  i_alu,
  input  logic [NB_REG-1:0]  i_b,
  input  logic [NB_MEM-1:0]  i_mem,
  input  logic [NB_WB-1:0]   i_wb,
  input  logic [NB_REG-1:0]  i_pc,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_REG-1:0]  o_dbg_data,
  output logic [NB_REG-1:0]  o_rdata,
  output logic [NB_REG-1:0]  o_alu,
  output logic [NB_WB-1:0]   o_wb,
  output logic [NB_REG-1:0]  o_pc
);

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         offset;
  size_e              size;
  logic               wr_en;
  logic [3:0]         wr_be;
  logic [NB_REG-1:0]  wr_data;
  logic [NB_REG-1:0]  rd_word;
  logic [NB_REG-1:0]  load_ext;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  assign word_idx = i_alu[NB_ADDR+1:2];
  assign offset   = i_alu[1:0];
  assign size     = size_e'(i_mem[MEM_SIZE_HI:MEM_SIZE_LO]);
  assign wr_en    = i_valid & i_mem[MEM_WRITE] & ~i_reset;
  assign wr_be    = byte_enable(size, offset);

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    case (size)
      SZ_BYTE: wr_data = {4{i_b[7:0]}};
      SZ_HALF: wr_data = {2{i_b[15:0]}};
      default: wr_data = i_b;
    endcase
  end

  data_memory #(
    .NB_REG  (NB_REG),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .i_clock    (i_clock),
    .i_we       (wr_en),
    .i_be       (wr_be),
    .i_addr     (word_idx),
    .i_wdata    (wr_data),
    .o_rdata    (rd_word),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      SZ_BYTE: load_ext = i_mem[MEM_UNSIGNED] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = i_mem[MEM_UNSIGNED] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = rd_word;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_rdata <= '0;
      o_alu   <= '0;
      o_wb    <= '0;
      o_pc    <= '0;
    end else if (i_valid) begin
      o_rdata <= i_mem[MEM_READ] ? load_ext : '0;
      o_alu   <= i_alu;
      o_wb    <= i_wb;
      o_pc    <= i_pc;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: a byte-array reference model predicts
// each cycle's outputs; a monitor compares them after every rising edge.
module tb_memory_access;

  localparam int NB_REG  = 32;
  localparam int NB_MEM  = 5;
  localparam int NB_WB   = 8;
  localparam int NB_ADDR = 10;
  localparam int NBYTES  = 4 * (2 ** NB_ADDR);

  logic               tb_clock_i;
  logic               tb_reset;
  logic               tb_valid;
  logic [NB_REG-1:0]  tb_alu;
  logic [NB_REG-1:0]  tb_b;
  logic [NB_MEM-1:0]  tb_mem;
  logic [NB_WB-1:0]   tb_wb;
  logic [NB_REG-1:0]  tb_pc;
  logic [NB_ADDR-1:0] tb_dbg_addr;
  logic [NB_REG-1:0]  tb_o_dbg_data;
  logic [NB_REG-1:0]  tb_o_rdata;
  logic [NB_REG-1:0]  tb_o_alu;
  logic [NB_WB-1:0]   tb_o_wb;
  logic [NB_REG-1:0]  tb_o_pc;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [7:0]  wb;
    logic [31:0] dbg;
    bit          dbg_known;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model_mem [NBYTES];
  bit          model_known [NBYTES];
  logic [31:0] held_rdata, held_alu, held_pc;
  logic [7:0]  held_wb;
  int          n_checks;
  int          n_fail;

  memory_access #(
    .NB_REG  (NB_REG),
    .NB_MEM  (NB_MEM),
    .NB_WB   (NB_WB),
    .NB_ADDR (NB_ADDR)
  ) dut (
    .i_clock    (tb_clock_i),
    .i_reset    (tb_reset),
    .i_valid    (tb_valid),
    .i_alu      (tb_alu),
    .i_b        (tb_b),
    .i_mem      (tb_mem),
    .i_wb       (tb_wb),
    .i_pc       (tb_pc),
    .i_dbg_addr (tb_dbg_addr),
    .o_dbg_data (tb_o_dbg_data),
    .o_rdata    (tb_o_rdata),
    .o_alu      (tb_o_alu),
    .o_wb       (tb_o_wb),
    .o_pc       (tb_o_pc)
  );

  initial begin
    tb_clock_i = 1'b0;
    forever #5 tb_clock_i = ~tb_clock_i;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int aligned_base(input logic [31:0] addr, input int nbytes);
    int a;
    a = int'(addr % 32'(NBYTES));
    return a - (a % nbytes);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int nbytes);
    logic [31:0] v;
    int base;
    base = aligned_base(addr, nbytes);
    v = 32'd0;
    for (int k = 0; k < nbytes; k++) v = v | (32'(model_mem[base + k]) << (8 * k));
    return v;
  endfunction

  function automatic bit model_is_known(input logic [31:0] addr);
    int base;
    base = aligned_base(addr, 4);
    return model_known[base] && model_known[base+1] && model_known[base+2] && model_known[base+3];
  endfunction

  // Drives one cycle from a falling edge and predicts the outputs after the next rising edge.
  task automatic applyStimulus(input logic valid, input logic reset, input logic [31:0] alu,
                               input logic [31:0] b, input logic [4:0] mem, input logic [7:0] wb,
                               input logic [31:0] pc, input logic [9:0] dbg_addr);
    exp_t        e;
    int          nb;
    int          base;
    logic [31:0] v;
    tb_valid = valid; tb_reset = reset; tb_alu = alu; tb_b = b;
    tb_mem = mem; tb_wb = wb; tb_pc = pc; tb_dbg_addr = dbg_addr;
    if (reset) begin
      #1;
      checkOutput("async_reset_rdata", tb_o_rdata, 32'd0);
      checkOutput("async_reset_alu", tb_o_alu, 32'd0);
      checkOutput("async_reset_pc", tb_o_pc, 32'd0);
      held_rdata = 32'd0; held_alu = 32'd0; held_pc = 32'd0; held_wb = 8'd0;
    end else if (valid) begin
      nb = size_bytes(mem[4:3]);
      v = 32'd0;
      if (mem[0]) begin
        v = model_read(alu, nb);
        if (nb < 4 && !mem[2] && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      end
      held_rdata = v; held_alu = alu; held_pc = pc; held_wb = wb;
      if (mem[1]) begin
        base = aligned_base(alu, nb);
        for (int k = 0; k < nb; k++) begin
          model_mem[base + k]   = 8'(b >> (8 * k));
          model_known[base + k] = 1'b1;
        end
      end
    end
    e.rdata = held_rdata; e.alu = held_alu; e.pc = held_pc; e.wb = held_wb;
    e.dbg = model_read({20'd0, dbg_addr, 2'b00}, 4);
    e.dbg_known = model_is_known({20'd0, dbg_addr, 2'b00});
    exp_q.push_back(e);
    @(negedge tb_clock_i);
  endtask

  task automatic do_op(input logic [1:0] sz, input logic uns, input logic wr, input logic rd,
                       input logic [31:0] alu, input logic [31:0] b, input logic [9:0] dbg_addr);
    applyStimulus(1'b1, 1'b0, alu, b, {sz, uns, wr, rd}, 8'($urandom), $urandom, dbg_addr);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge tb_clock_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rdata", tb_o_rdata, e.rdata);
        checkOutput("alu", tb_o_alu, e.alu);
        checkOutput("pc", tb_o_pc, e.pc);
        checkOutput("wb", {24'd0, tb_o_wb}, {24'd0, e.wb});
        if (e.dbg_known) checkOutput("dbg_data", tb_o_dbg_data, e.dbg);
      end
    end
  end

  initial begin
    logic [31:0] saved;
    logic [4:0]  rmem;
    n_checks = 0; n_fail = 0;
    held_rdata = 32'd0; held_alu = 32'd0; held_pc = 32'd0; held_wb = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      model_mem[i] = 8'd0;
      model_known[i] = 1'b0;
    end
    tb_reset = 1'b1; tb_valid = 1'b0; tb_alu = '0; tb_b = '0;
    tb_mem = '0; tb_wb = '0; tb_pc = '0; tb_dbg_addr = '0;
    #1;
    checkOutput("reset_rdata", tb_o_rdata, 32'd0);
    checkOutput("reset_wb", {24'd0, tb_o_wb}, 32'd0);
    @(negedge tb_clock_i);
    applyStimulus(1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 8'd0, 32'd0, 10'd0);

    for (int i = 0; i < 2 ** NB_ADDR; i++) do_op(2'b10, 1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom, 10'(i));

    $display("[TB] directed accesses");
    do_op(2'b10, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 10'd4);
    do_op(2'b10, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 10'd4);
    checkOutput("tp1_load_word", tb_o_rdata, 32'hDEADBEEF);
    checkOutput("tp1_alu", tb_o_alu, 32'h10);

    saved = model_read(32'h20, 4);
    do_op(2'b00, 1'b0, 1'b1, 1'b0, 32'h22, 32'h12345680, 10'd8);
    checkOutput("tp2_dbg_word8", tb_o_dbg_data, {saved[31:24], 8'h80, saved[15:0]});
    do_op(2'b00, 1'b0, 1'b0, 1'b1, 32'h22, 32'h0, 10'd8);
    checkOutput("tp2_load_sbyte", tb_o_rdata, 32'hFFFFFF80);
    do_op(2'b00, 1'b1, 1'b0, 1'b1, 32'h22, 32'h0, 10'd8);
    checkOutput("tp2_load_ubyte", tb_o_rdata, 32'h00000080);

    saved = model_read(32'h30, 4);
    do_op(2'b01, 1'b0, 1'b1, 1'b0, 32'h33, 32'hABCD8001, 10'd12);
    do_op(2'b01, 1'b0, 1'b0, 1'b1, 32'h32, 32'h0, 10'd12);
    checkOutput("tp3_load_shalf", tb_o_rdata, 32'hFFFF8001);
    do_op(2'b01, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 10'd12);
    checkOutput("tp3_load_uhalf_low", tb_o_rdata, {16'd0, saved[15:0]});

    do_op(2'b10, 1'b0, 1'b1, 1'b0, 32'h40, 32'h11111111, 10'd16);
    do_op(2'b10, 1'b0, 1'b1, 1'b1, 32'h40, 32'h22222222, 10'd16);
    checkOutput("tp4_read_before_write", tb_o_rdata, 32'h11111111);
    do_op(2'b10, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 10'd16);
    checkOutput("tp4_load_after", tb_o_rdata, 32'h22222222);

    do_op(2'b10, 1'b0, 1'b0, 1'b1, 32'h50, 32'h0, 10'd20);
    saved = tb_o_rdata;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 32'h50, 32'hCAFEF00D, 5'b10010, 8'h5A, 32'h1234, 10'd20);
    checkOutput("tp5_stall_hold", tb_o_rdata, saved);
    do_op(2'b10, 1'b0, 1'b0, 1'b1, 32'h50, 32'h0, 10'd20);
    checkOutput("tp5_mem_unchanged", tb_o_rdata, saved);

    saved = model_read(32'h60, 4);
    do_op(2'b10, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 10'd24);
    applyStimulus(1'b1, 1'b1, 32'h60, ~saved, 5'b10010, 8'h77, 32'h400, 10'd24);
    applyStimulus(1'b1, 1'b1, 32'h60, ~saved, 5'b10010, 8'h77, 32'h400, 10'd24);
    do_op(2'b10, 1'b0, 1'b0, 1'b1, 32'h60, 32'h0, 10'd24);
    checkOutput("tp6_reset_blocks_store", tb_o_rdata, saved);
    do_op(2'b10, 1'b0, 1'b1, 1'b0, 32'h4010, 32'h13579BDF, 10'd4);
    checkOutput("tp6_wrap_dbg", tb_o_dbg_data, 32'h13579BDF);
    do_op(2'b10, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 10'd4);
    checkOutput("tp6_wrap_load", tb_o_rdata, 32'h13579BDF);

    $display("[TB] random accesses");
    for (int i = 0; i < 3000; i++) begin
      rmem = 5'($urandom);
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0), $urandom, $urandom,
                    rmem, 8'($urandom), $urandom, 10'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 8'd0, 32'd0, 10'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge tb_clock_i);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the MIPS pipeline. It sits directly downstream of the execution stage and consumes that stage's registered outputs: ALU result, forwarded B operand, MEM and WB control fields, and PC. It performs byte, half-word or word loads and stores into an internal byte-enabled data memory. It registers the load result together with the pass-through fields for the write-back stage.

## Interface
Parameters:
- NB_REG, 32, datapath/address width
- NB_MEM, 5, MEM control field width
- NB_WB, 8, WB control field width
- NB_ADDR, 10, data memory word-address width (depth 2**NB_ADDR words)

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  throughput enable; low = stall (hold all registers, no store)
- i_alu  in  NB_REG  effective byte address / ALU result from execution
- i_b  in  NB_REG  store data from execution
- i_mem  in  NB_MEM  [0] read, [1] write, [2] unsigned, [4:3] size (00 byte, 01 half, 10 word, 11 word)
- i_wb  in  NB_WB  write-back control, passed through
- i_pc  in  NB_REG  PC, passed through
- i_dbg_addr  in  NB_ADDR  debug word address
- o_dbg_data  out  NB_REG  debug read, combinational, raw word
- o_rdata  out  NB_REG  extended load data
- o_alu  out  NB_REG  registered i_alu
- o_wb  out  NB_WB  registered i_wb
- o_pc  out  NB_REG  registered i_pc

## Operation
- Word index = i_alu[NB_ADDR+1:2]. Upper address bits are ignored, so addresses wrap modulo depth. Byte offset = i_alu[1:0]. Memory is little-endian.
- Alignment is forced. Half accesses ignore i_alu[0]. Word accesses ignore i_alu[1:0]. No exception is raised.
- Store (i_mem[1]=1, i_valid=1): byte enables are taken from size and offset.
  - byte: lane = offset, data = i_b[7:0]
  - half: lanes {2*off[1]+1, 2*off[1]}, data = i_b[15:0]
  - word: all lanes, data = i_b
- Load (i_mem[0]=1): the addressed word is read combinationally (pre-write contents), then the selected byte or half is extracted. The value is zero-extended if i_mem[2]=1, otherwise sign-extended, and registered into o_rdata.
- If no read is requested, o_rdata is loaded with 0.
- Read and write in the same cycle: the store commits at the edge, and o_rdata reflects the old contents (read-before-write).
- i_valid=0: all output registers hold and the memory is not written.
- Memory contents are not cleared by reset.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on all outputs after edge N. Throughput is one access per cycle.
- A store is visible to a load presented on the next cycle, and to o_dbg_data immediately after the edge.
- Reset values: o_rdata=0, o_alu=0, o_wb=0, o_pc=0. These take effect asynchronously on i_reset assertion.
- While i_reset is high, no store commits, including a store presented in the same cycle as reset.
- Release is synchronous to the clock edge. The first capture happens on the first rising edge after i_reset falls.

## Structure
- Shared package (mips_pkg): MEM bit positions (MEM_READ=0, MEM_WRITE=1, MEM_UNSIGNED=2, MEM_SIZE=4:3), size codes SZ_BYTE/SZ_HALF/SZ_WORD, NB_MEM/NB_WB defaults.
- Sub-module data_memory: NB_REG-wide, 2**NB_ADDR deep, 4-bit byte-enable synchronous write, two async read ports (access and debug).
- The top level contains byte-enable generation, load extraction/extension, and the output pipeline register.

## Test plan
- Store word i_alu=0x10, i_b=0xDEADBEEF, then load word 0x10 → o_rdata=0xDEADBEEF one cycle later; o_alu=0x10; o_wb/o_pc match the inputs.
- Store byte 0x80 at 0x22, then load signed byte 0x22 → 0xFFFFFF80; load unsigned → 0x00000080; o_dbg_data(word 8) shows byte lane 2 = 0x80 with other lanes unchanged.
- Store half 0x8001 at 0x33 (forced to 0x32), then load signed half 0x32 → 0xFFFF8001; load unsigned half 0x30 → the untouched lower half.
- Read+write same cycle at 0x40 (old 0x11111111, new 0x22222222) → o_rdata=0x11111111; next load → 0x22222222.
- i_valid=0 for 3 cycles with a store to 0x50 presented → outputs hold their last values and memory word 0x50 is unchanged.
- Assert i_reset mid-sequence with a store pending → outputs go to 0 immediately and the store does not commit; address 0x4010 with NB_ADDR=10 wraps to word 4.
